// File: rtl/day10_accum_multi.sv
`default_nettype none
// ============================================================================
// Module      : day10_accum_multi
// Description : Per-machine result accumulator for the day-10 solver.
//               Sums NUM_PARTS unsigned press counts per accepted item into
//               NUM_PARTS accumulators, counts accepted items and keeps a
//               sticky per-channel overflow flag. One registered input stage
//               feeds the adders; a three-state controller (ACCUM, DRAIN,
//               DONE) tracks job progress.
// Options     : SATURATE_EN - when defined, an overflowing channel clamps to
//               all-ones until load/reset; otherwise it wraps modulo
//               2^ACC_WIDTH. The overflow flags are the same in both builds.
// Revision    : 1.0 - initial release
// ============================================================================
module day10_accum_multi #(
    parameter int NUM_PARTS   = 2,
    parameter int IN_WIDTH    = 32,
    parameter int ACC_WIDTH   = 64,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                           clock,
    input  logic                           clear_n,
    input  logic                           load,
    input  logic                           item_valid,
    input  logic                           item_last,
    input  logic [NUM_PARTS*IN_WIDTH-1:0]  item_data,
    output logic                           ready,
    output logic                           done_,
    output logic [NUM_PARTS*ACC_WIDTH-1:0] results,
    output logic [COUNT_WIDTH-1:0]         item_count,
    output logic [NUM_PARTS-1:0]           overflow
);

    // Controller state encoding
    localparam logic [1:0] c_ST_ACCUM = 2'd0;
    localparam logic [1:0] c_ST_DRAIN = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;

    localparam logic [COUNT_WIDTH-1:0] c_COUNT_ONE = COUNT_WIDTH'(1);

    // Controller and job status
    logic [1:0]                     r_state;
    logic                           r_done;

    // Stage-1 capture of the accepted item
    logic                           r_s1_valid;
    logic                           r_s1_last;
    logic [NUM_PARTS*IN_WIDTH-1:0]  r_s1_data;

    // Accumulators, item counter and sticky overflow flags
    logic [NUM_PARTS*ACC_WIDTH-1:0] r_acc;
    logic [COUNT_WIDTH-1:0]         r_count;
    logic [NUM_PARTS-1:0]           r_overflow;

    // Next-value datapath
    logic                           w_ready;
    logic                           w_accept;
    logic [NUM_PARTS*ACC_WIDTH-1:0] w_next_acc;
    logic [NUM_PARTS-1:0]           w_carry;

    // A load in the same cycle always wins over an incoming item, so ready
    // has to drop combinationally with load.
    assign w_ready  = (r_state == c_ST_ACCUM) && !load;
    assign w_accept = item_valid && w_ready;

    // Per-channel adder: zero-extended input plus one carry bit to detect
    // overflow out of the accumulator MSB.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_PARTS; gi++) begin : g_chan
            logic [ACC_WIDTH:0] w_sum;

            assign w_sum = {1'b0, r_acc[gi*ACC_WIDTH +: ACC_WIDTH]}
                         + {{(ACC_WIDTH-IN_WIDTH+1){1'b0}},
                            r_s1_data[gi*IN_WIDTH +: IN_WIDTH]};

            assign w_carry[gi] = w_sum[ACC_WIDTH];

`ifdef SATURATE_EN
            // Once clamped, any non-zero add carries again, so the channel
            // stays pinned at all-ones until the next load or reset.
            assign w_next_acc[gi*ACC_WIDTH +: ACC_WIDTH] =
                w_sum[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : w_sum[ACC_WIDTH-1:0];
`else
            assign w_next_acc[gi*ACC_WIDTH +: ACC_WIDTH] = w_sum[ACC_WIDTH-1:0];
`endif
        end
    endgenerate

    // Input stage capture: holds the item accepted on the previous edge.
    always_ff @(posedge clock) begin
        if (!clear_n || load) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_data  <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_last <= item_last;
                r_s1_data <= item_data;
            end
        end
    end

    // Accumulate the staged item into every channel and count it.
    always_ff @(posedge clock) begin
        if (!clear_n || load) begin
            r_acc      <= '0;
            r_count    <= '0;
            r_overflow <= '0;
        end else if (r_s1_valid) begin
            r_acc      <= w_next_acc;
            r_count    <= r_count + c_COUNT_ONE;
            r_overflow <= r_overflow | w_carry;
        end
    end

    // Job controller with registered done flag.
    always_ff @(posedge clock) begin
        if (!clear_n || load) begin
            r_state <= c_ST_ACCUM;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                c_ST_ACCUM: begin
                    // The final item is in stage 1 after this edge; it lands
                    // in the accumulators on the next one.
                    if (w_accept && item_last) begin
                        r_state <= c_ST_DRAIN;
                    end
                    r_done <= 1'b0;
                end
                c_ST_DRAIN: begin
                    // Stage 1 always holds the final item while draining, so
                    // this edge completes the job and results become final.
                    if (r_s1_valid && r_s1_last) begin
                        r_state <= c_ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                c_ST_DONE: begin
                    r_done <= 1'b1;
                end
                default: begin
                    r_state <= c_ST_ACCUM;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign ready      = w_ready;
    assign done_      = r_done;
    assign results    = r_acc;
    assign item_count = r_count;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire
